// File: rtl/spi_host_pkg.sv
// Shared definitions for the SPI host: transfer sizing, engine states and
// the bit-index helper used by both the launch and sample paths.
package spi_host_pkg;

    localparam int MAX_LEN = 128;
    localparam int LEN_W   = 7;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_e;

    // Maps a running bit count onto the word index for the selected bit order.
    function automatic logic [LEN_W-1:0] bit_idx(
        input logic [LEN_W:0] cnt,
        input logic [LEN_W:0] len_eff,
        input logic           lsb_first
    );
        logic [LEN_W:0] rev;
        rev = len_eff - (LEN_W+1)'(1) - cnt;
        return lsb_first ? cnt[LEN_W-1:0] : rev[LEN_W-1:0];
    endfunction

endpackage

// File: rtl/spi_edge_sel.sv
// Routes the clock generator strobes onto the launch and sample paths
// according to the polarity bits latched at the start of a transfer.
module spi_edge_sel (
    input  logic pos_edge_i,
    input  logic neg_edge_i,
    input  logic tx_negedge_i,
    input  logic rx_negedge_i,
    input  logic active_i,
    output logic tx_edge_o,
    output logic rx_edge_o
);

    assign tx_edge_o = active_i & (tx_negedge_i ? neg_edge_i : pos_edge_i);
    assign rx_edge_o = active_i & (rx_negedge_i ? neg_edge_i : pos_edge_i);

endmodule

// File: rtl/spi_shift_engine.sv
// SPI host serial engine: loads a parallel word on go, shifts it out on MOSI,
// assembles MISO into rx_data and pulses done after the programmed bit count.
//
//   state | meaning
//   IDLE  | waiting for go; strobes ignored, rx_data held
//   XFER  | shifting; tip high, counters advance on selected strobes
module spi_shift_engine
    import spi_host_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               go,
    input  logic [LEN_W-1:0]   len,
    input  logic               lsb_first,
    input  logic               tx_negedge,
    input  logic               rx_negedge,
    input  logic               pos_edge,
    input  logic               neg_edge,
    input  logic [MAX_LEN-1:0] tx_data,
    input  logic               s_in,
    output logic               s_out,
    output logic               tip,
    output logic               last_clk,
    output logic [MAX_LEN-1:0] rx_data,
    output logic               done
);

    state_e               state_q, state_d;
    logic [MAX_LEN-1:0]   tx_q, tx_d;
    logic [MAX_LEN-1:0]   rx_q, rx_d;
    logic [LEN_W:0]       len_q, len_d;
    logic [LEN_W:0]       tx_cnt_q, tx_cnt_d;
    logic [LEN_W:0]       rx_cnt_q, rx_cnt_d;
    logic                 lsb_q, lsb_d;
    logic                 txneg_q, txneg_d;
    logic                 rxneg_q, rxneg_d;
    logic                 s_out_q, s_out_d;
    logic                 done_q, done_d;
    logic                 tx_edge, rx_edge;
    logic [LEN_W:0]       len_in;

    assign len_in = (len == '0) ? (LEN_W+1)'(MAX_LEN) : {1'b0, len};

    spi_edge_sel u_edge_sel (
        .pos_edge_i   (pos_edge),
        .neg_edge_i   (neg_edge),
        .tx_negedge_i (txneg_q),
        .rx_negedge_i (rxneg_q),
        .active_i     (state_q == XFER),
        .tx_edge_o    (tx_edge),
        .rx_edge_o    (rx_edge)
    );

    always_comb begin
        state_d  = state_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        len_d    = len_q;
        tx_cnt_d = tx_cnt_q;
        rx_cnt_d = rx_cnt_q;
        lsb_d    = lsb_q;
        txneg_d  = txneg_q;
        rxneg_d  = rxneg_q;
        s_out_d  = s_out_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (go) begin
                    tx_d     = tx_data;
                    len_d    = len_in;
                    lsb_d    = lsb_first;
                    txneg_d  = tx_negedge;
                    rxneg_d  = rx_negedge;
                    rx_d     = '0;
                    s_out_d  = tx_data[bit_idx('0, len_in, lsb_first)];
                    tx_cnt_d = (LEN_W+1)'(1);
                    rx_cnt_d = '0;
                    state_d  = XFER;
                end
            end
            XFER: begin
                if (tx_edge && (tx_cnt_q < len_q)) begin
                    s_out_d  = tx_q[bit_idx(tx_cnt_q, len_q, lsb_q)];
                    tx_cnt_d = tx_cnt_q + (LEN_W+1)'(1);
                end
                // Sampling uses the pre-edge s_in, so a shared edge samples before launching.
                if (rx_edge && (rx_cnt_q < len_q)) begin
                    rx_d[bit_idx(rx_cnt_q, len_q, lsb_q)] = s_in;
                    rx_cnt_d = rx_cnt_q + (LEN_W+1)'(1);
                    if (rx_cnt_d == len_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            tx_q     <= '0;
            rx_q     <= '0;
            len_q    <= '0;
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
            lsb_q    <= 1'b0;
            txneg_q  <= 1'b0;
            rxneg_q  <= 1'b0;
            s_out_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            len_q    <= len_d;
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;
            lsb_q    <= lsb_d;
            txneg_q  <= txneg_d;
            rxneg_q  <= rxneg_d;
            s_out_q  <= s_out_d;
            done_q   <= done_d;
        end
    end

    assign s_out    = s_out_q;
    assign tip      = (state_q == XFER);
    assign last_clk = tip && (tx_cnt_q == len_q);
    assign rx_data  = rx_q;
    assign done     = done_q;

endmodule

// File: doc/spi_shift_engine.md
Name: spi_shift_engine

Overview:
- Serial data engine for the SPI host master. It sits directly downstream of the SPI clock generator and consumes that block's pos_edge/neg_edge strobes.
- It drives the generator's enable (tip) and last_clk inputs.
- It loads a parallel TX word on go, shifts it out on MOSI, samples MISO into a parallel RX word, and pulses done when the programmed bit count completes.

Parameters:
- MAX_LEN, 128, maximum transfer length in bits; also the width of the tx_data and rx_data buses.
- LEN_W, 7, width of the len field, equal to clog2(MAX_LEN); a len value of 0 encodes MAX_LEN.

Ports:
- clk_i  input  1  system clock
- rst_ni  input  1  asynchronous active-low reset
- go  input  1  start-transfer pulse, single cycle
- len  input  LEN_W  transfer length in bits; 0 means MAX_LEN; sampled on an accepted go
- lsb_first  input  1  1 = bit 0 is sent first; sampled on an accepted go
- tx_negedge  input  1  1 = advance MOSI on neg_edge, 0 = on pos_edge; sampled on go
- rx_negedge  input  1  1 = sample MISO on neg_edge, 0 = on pos_edge; sampled on go
- pos_edge  input  1  rising-edge strobe from the clock generator
- neg_edge  input  1  falling-edge strobe from the clock generator
- tx_data  input  MAX_LEN  parallel transmit word; sampled on an accepted go
- s_in  input  1  MISO
- s_out  output  1  MOSI, registered
- tip  output  1  transfer in progress; drives the clock generator's enable
- last_clk  output  1  all bits launched; drives the clock generator's last_clk
- rx_data  output  MAX_LEN  parallel receive word
- done  output  1  one-cycle pulse at the end of a transfer

Behaviour:
- Reset values: s_out=0, tip=0, done=0, rx_data=0, tx_cnt=0, rx_cnt=0, all latched configuration=0, state=IDLE.
- Effective length: len_eff = (len==0) ? MAX_LEN : len. Both counters are LEN_W+1 bits wide and never wrap.
- States: IDLE and XFER.
- IDLE, on go:
  - latch tx_data, len_eff, lsb_first, tx_negedge and rx_negedge;
  - clear rx_data to 0;
  - s_out <= first bit (tx_data[0] if lsb_first, else tx_data[len_eff-1]);
  - tx_cnt <= 1, rx_cnt <= 0, tip <= 1, go to XFER.
  - The first bit is therefore valid one cycle after go, before any SCK edge.
- Edge selection: tx_edge = tx_negedge ? neg_edge : pos_edge; rx_edge = rx_negedge ? neg_edge : pos_edge. Both strobes are ignored in IDLE.
- XFER, tx_edge with tx_cnt < len_eff:
  - s_out <= bit at index (lsb_first ? tx_cnt : len_eff-1-tx_cnt);
  - tx_cnt++.
- XFER, tx_edge with tx_cnt == len_eff: s_out holds its value.
- XFER, rx_edge:
  - rx_data[lsb_first ? rx_cnt : len_eff-1-rx_cnt] <= s_in;
  - rx_cnt++.
  - When this edge makes rx_cnt == len_eff: next cycle tip=0, done=1 for one cycle, state=IDLE.
- last_clk is combinational: tip && (tx_cnt == len_eff).
- Simultaneous tx_edge and rx_edge in the same cycle (same polarity selected): both actions occur; MISO is sampled before the next bit is launched.
- go while in XFER: ignored; latched configuration and counters are unchanged.
- go in the same cycle as done: accepted, and a new transfer starts back-to-back.
- rx_data bits at index >= len_eff stay 0. rx_data is stable from done until the next accepted go.
- Async reset mid-transfer: all state returns to reset values immediately; no done pulse is produced.
- Config inputs may change freely during XFER; only the values latched at go are used.

Decomposition:
- Shared package spi_host_pkg holds:
  - the state enum (IDLE, XFER);
  - MAX_LEN and LEN_W constants, shared with the clock generator's SPI_DIVIDER_LEN;
  - a bit-index helper function taking (cnt, len_eff, lsb_first) and returning the index.
- One sub-module is natural: spi_edge_sel, which muxes pos_edge/neg_edge into tx_edge/rx_edge from the latched polarity bits.
- Everything else stays flat.

Test Plan:
- Mode 0, MSB first, len=8, tx_data=0xA5, s_in looped to s_out, pos_edge/neg_edge alternating every 2 cycles, tx_negedge=1, rx_negedge=0 -> s_out sequence 1,0,1,0,0,1,0,1; rx_data=0xA5; done pulses exactly once after the 8th pos_edge; tip low the same cycle done is high.
- LSB first, len=4, tx_data=0x3, s_in tied 1 -> s_out sequence 1,1,0,0; rx_data=0xF with bits [127:4]=0.
- len=0 (MAX_LEN=128), tx_data=all-ones -> exactly 128 rx_edges accepted; last_clk asserted once tx_cnt=128; done after the 128th rx_edge.
- go asserted twice mid-transfer plus a strobe while IDLE -> no counter or s_out change; a single done for the original transfer.
- rst_ni pulled low after 3 bits of an 8-bit transfer -> tip=0, s_out=0, rx_data=0, no done; a subsequent go runs a clean 8-bit transfer.
- go coincident with the done cycle -> second transfer starts with no idle cycle; its first bit appears on s_out one cycle later.
